// File: rtl/conv_window_scheduler_pkg.sv
// Shared types and geometry helpers for the sliding-window scheduler.
package conv_window_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Output-map edge length; zero when the kernel does not fit the image.
   function automatic int out_dim(input int n, input int k, input int s);
      return (n < k) ? 0 : (n - k) / s + 1;
   endfunction

   function automatic int phase_w(input int s);
      return (s > 1) ? $clog2(s) : 1;
   endfunction

   localparam int DEF_KERNEL_SIZE = 3;
   localparam int DEF_DATA_SIZE   = 16;
   localparam int DEF_ROW_SIZE    = 5;
   localparam int DEF_COLUMN_SIZE = 5;
   localparam int DEF_STRIDE      = 1;

   localparam int ROW_W         = $clog2(DEF_COLUMN_SIZE);
   localparam int COL_W         = $clog2(DEF_ROW_SIZE);
   localparam int OUT_ROWS      = out_dim(DEF_COLUMN_SIZE, DEF_KERNEL_SIZE, DEF_STRIDE);
   localparam int OUT_COLS      = out_dim(DEF_ROW_SIZE, DEF_KERNEL_SIZE, DEF_STRIDE);
   localparam int WIN_PER_FRAME = OUT_ROWS * OUT_COLS;

endpackage

// File: rtl/conv_window_scheduler_raster_position_counter.sv
// Raster row/column tracking, stride phases, legal-window detection and
// output-map coordinates for the window scheduler.
module raster_position_counter
   import conv_window_scheduler_pkg::*;
#(
   parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int ROW_SIZE    = DEF_ROW_SIZE,
   parameter int COLUMN_SIZE = DEF_COLUMN_SIZE,
   parameter int STRIDE      = DEF_STRIDE
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           push,
   output logic                           legal,
   output logic                           last,
   output logic [$clog2(COLUMN_SIZE)-1:0] out_row,
   output logic [$clog2(ROW_SIZE)-1:0]    out_col
);

   localparam int RW = $clog2(COLUMN_SIZE);
   localparam int CW = $clog2(ROW_SIZE);
   localparam int PW = phase_w(STRIDE);
   localparam logic [PW-1:0] PH_MAX = PW'(STRIDE - 1);

   logic [RW-1:0] row, win_row;
   logic [CW-1:0] col, win_col;
   logic [PW-1:0] rph, cph;
   logic          row_last, col_last, row_in, col_in;

   assign row_last = (int'(row) == COLUMN_SIZE - 1);
   assign col_last = (int'(col) == ROW_SIZE - 1);
   assign row_in   = (int'(row) >= KERNEL_SIZE - 1);
   assign col_in   = (int'(col) >= KERNEL_SIZE - 1);
   assign legal    = row_in && col_in && (rph == '0) && (cph == '0);
   assign last     = row_last && col_last;

   // win_row/win_col are the coordinates the next legal window will carry.
   always_ff @(posedge clock) begin
      if (reset) begin
         row     <= '0;
         col     <= '0;
         rph     <= '0;
         cph     <= '0;
         win_row <= '0;
         win_col <= '0;
         out_row <= '0;
         out_col <= '0;
      end else if (push) begin
         if (legal) begin
            out_row <= win_row;
            out_col <= win_col;
            win_col <= win_col + CW'(1);
         end
         if (col_last) begin
            col     <= '0;
            cph     <= '0;
            win_col <= '0;
            if (row_last) begin
               row     <= '0;
               rph     <= '0;
               win_row <= '0;
            end else begin
               row <= row + RW'(1);
               rph <= !row_in ? '0 : ((rph == PH_MAX) ? '0 : rph + PW'(1));
               if (row_in && (rph == '0))
                  win_row <= win_row + RW'(1);
            end
         end else begin
            col <= col + CW'(1);
            cph <= !col_in ? '0 : ((cph == PH_MAX) ? '0 : cph + PW'(1));
         end
      end
   end

endmodule

// File: rtl/conv_window_scheduler.sv
// Frame sequencer and pixel/window handshake for the line-buffer datapath.
//   state | meaning
//   IDLE  | waiting for start, no pixels accepted
//   RUN   | accepting pixels, windows flagged as they complete
//   DRAIN | last pixel taken, waiting for the final window to be consumed
//   DONE  | one-cycle frame_done, back to IDLE
module conv_window_scheduler
   import conv_window_scheduler_pkg::*;
#(
   parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int DATA_SIZE   = DEF_DATA_SIZE,
   parameter int ROW_SIZE    = DEF_ROW_SIZE,
   parameter int COLUMN_SIZE = DEF_COLUMN_SIZE,
   parameter int STRIDE      = DEF_STRIDE
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           in_valid,
   input  logic [DATA_SIZE-1:0]           in_data,
   output logic                           in_ready,
   output logic                           buf_push,
   output logic [DATA_SIZE-1:0]           buf_data,
   output logic                           win_valid,
   input  logic                           win_ready,
   output logic [$clog2(COLUMN_SIZE)-1:0] out_row,
   output logic [$clog2(ROW_SIZE)-1:0]    out_col,
   output logic                           busy,
   output logic                           frame_done
);

   state_t state_q, state_d;
   logic   legal, last;

   // The buffer must not shift while a window is still waiting downstream.
   assign in_ready   = (state_q == ST_RUN) && (!win_valid || win_ready);
   assign buf_push   = in_valid && in_ready;
   assign buf_data   = in_data;
   assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign frame_done = (state_q == ST_DONE);

   raster_position_counter #(
      .KERNEL_SIZE (KERNEL_SIZE),
      .ROW_SIZE    (ROW_SIZE),
      .COLUMN_SIZE (COLUMN_SIZE),
      .STRIDE      (STRIDE)
   ) u_pos (
      .clock   (clock),
      .reset   (reset),
      .push    (buf_push),
      .legal   (legal),
      .last    (last),
      .out_row (out_row),
      .out_col (out_col)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         win_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         if (buf_push)
            win_valid <= legal;
         else if (win_ready)
            win_valid <= 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (buf_push && last) state_d = ST_DRAIN;
         ST_DRAIN: if (!win_valid || win_ready) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench: default 5x5 K=3 instance, a stride-2 instance and a
// 3x2 instance that cannot hold any window.
module tb_conv_window_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] in_data;

   logic        s1_start, s1_in_valid, s1_win_ready;
   logic        s1_in_ready, s1_buf_push, s1_win_valid, s1_busy, s1_frame_done;
   logic [15:0] s1_buf_data;
   logic [2:0]  s1_out_row, s1_out_col;

   logic        s2_start, s2_in_valid, s2_win_ready;
   logic        s2_in_ready, s2_buf_push, s2_win_valid, s2_busy, s2_frame_done;
   logic [15:0] s2_buf_data;
   logic [2:0]  s2_out_row, s2_out_col;

   logic        sm_start, sm_in_valid, sm_win_ready;
   logic        sm_in_ready, sm_buf_push, sm_win_valid, sm_busy, sm_frame_done;
   logic [15:0] sm_buf_data;
   logic [0:0]  sm_out_row;
   logic [1:0]  sm_out_col;

   int tests  = 0;
   int failed = 0;

   always #5 clock = ~clock;

   conv_window_scheduler u_s1 (
      .clock(clock), .reset(reset), .start(s1_start), .in_valid(s1_in_valid),
      .in_data(in_data), .in_ready(s1_in_ready), .buf_push(s1_buf_push),
      .buf_data(s1_buf_data), .win_valid(s1_win_valid), .win_ready(s1_win_ready),
      .out_row(s1_out_row), .out_col(s1_out_col), .busy(s1_busy),
      .frame_done(s1_frame_done));

   conv_window_scheduler #(.STRIDE(2)) u_s2 (
      .clock(clock), .reset(reset), .start(s2_start), .in_valid(s2_in_valid),
      .in_data(in_data), .in_ready(s2_in_ready), .buf_push(s2_buf_push),
      .buf_data(s2_buf_data), .win_valid(s2_win_valid), .win_ready(s2_win_ready),
      .out_row(s2_out_row), .out_col(s2_out_col), .busy(s2_busy),
      .frame_done(s2_frame_done));

   conv_window_scheduler #(.ROW_SIZE(3), .COLUMN_SIZE(2)) u_sm (
      .clock(clock), .reset(reset), .start(sm_start), .in_valid(sm_in_valid),
      .in_data(in_data), .in_ready(sm_in_ready), .buf_push(sm_buf_push),
      .buf_data(sm_buf_data), .win_valid(sm_win_valid), .win_ready(sm_win_ready),
      .out_row(sm_out_row), .out_col(sm_out_col), .busy(sm_busy),
      .frame_done(sm_frame_done));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One 5x5 frame on the default instance. Windows are raster ordered, so
   // window w sits at (w/3, w%3) and completes on pixel (w/3+2)*5 + w%3+2.
   task automatic run_s1(input string tag, input bit rnd, input int stall_win);
      int  pushes = 0, wins = 0, fd_cnt = 0, last_hs = -100, post = 0;
      int  stall_left = 0, cur_w;
      bit  pending = 0, fd_seen = 0, new_win;
      @(negedge clock);
      s1_start = 1'b1; s1_in_valid = 1'b0; s1_win_ready = 1'b1;
      @(negedge clock);
      s1_start = 1'b0;
      for (int cyc = 0; cyc < 400 && post < 3; cyc++) begin
         s1_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         s1_start    = rnd && !fd_seen && (cyc % 5 == 2);
         in_data     = 16'($urandom);
         #1;
         if (cyc == 0) check({tag, " busy_run"}, s1_busy, 1);
         new_win = s1_win_valid && !pending;
         if (new_win) begin
            cur_w = wins;
            check({tag, " win_row"}, s1_out_row, cur_w / 3);
            check({tag, " win_col"}, s1_out_col, cur_w % 3);
            check({tag, " win_pixel"}, pushes, (cur_w / 3 + 2) * 5 + (cur_w % 3 + 2) + 1);
            wins++;
            if (cur_w == stall_win) stall_left = 3;
         end
         s1_win_ready = (stall_left == 0);
         #1;
         if (stall_left > 0) begin
            check({tag, " stall_in_ready"}, s1_in_ready, 0);
            check({tag, " stall_push"}, s1_buf_push, 0);
            check({tag, " stall_valid"}, s1_win_valid, 1);
            check({tag, " stall_coord"}, {s1_out_row, s1_out_col}, {3'd1, 3'd1});
            stall_left--;
         end
         if (!rnd && stall_win < 0 && cyc < 25)
            check({tag, " throughput"}, s1_buf_push, 1);
         if (s1_frame_done) begin
            fd_cnt++;
            if (!fd_seen) begin
               fd_seen = 1;
               check({tag, " fd_after_hs"}, cyc - last_hs, 1);
               if (!rnd) check({tag, " fd_cycle"}, cyc, (stall_win >= 0) ? 29 : 26);
            end
         end
         if (fd_seen) post++;
         if (s1_win_valid && s1_win_ready) last_hs = cyc;
         if (s1_buf_push) pushes++;
         pending = s1_win_valid && !s1_win_ready;
         @(negedge clock);
      end
      s1_in_valid = 1'b0; s1_start = 1'b0; s1_win_ready = 1'b1;
      #1;
      check({tag, " windows"}, wins, 9);
      check({tag, " pushes"}, pushes, 25);
      check({tag, " frame_done_cnt"}, fd_cnt, 1);
      check({tag, " idle_busy"}, s1_busy, 0);
   endtask

   initial begin
      int w2 = 0, p2 = 0, fd2 = 0;
      int wm = 0, pm = 0, fdm_cyc = -1;

      reset = 1'b1; in_data = 16'h1234;
      s1_start = 0; s1_in_valid = 1; s1_win_ready = 1;
      s2_start = 0; s2_in_valid = 0; s2_win_ready = 1;
      sm_start = 0; sm_in_valid = 0; sm_win_ready = 1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst in_ready", s1_in_ready, 0);
      check("rst buf_push", s1_buf_push, 0);
      check("rst win_valid", s1_win_valid, 0);
      check("rst busy", s1_busy, 0);
      check("rst frame_done", s1_frame_done, 0);
      check("rst out_row", s1_out_row, 0);
      check("rst out_col", s1_out_col, 0);
      check("buf_data pass", s1_buf_data, 16'h1234);
      s1_in_valid = 0;

      run_s1("s1", 0, -1);
      run_s1("stall", 0, 4);

      // Abort a frame after 8 pushes, then run a clean frame.
      @(negedge clock);
      s1_start = 1'b1;
      @(negedge clock);
      s1_start = 1'b0; s1_in_valid = 1'b1; s1_win_ready = 1'b1;
      repeat (8) @(negedge clock);
      s1_in_valid = 1'b0; reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("midrst busy", s1_busy, 0);
      check("midrst win_valid", s1_win_valid, 0);
      check("midrst in_ready", s1_in_ready, 0);
      check("midrst coord", {s1_out_row, s1_out_col}, 0);
      run_s1("rst", 0, -1);

      run_s1("rnd", 1, -1);

      // Stride 2: windows from pixels 12, 14, 22, 24.
      @(negedge clock);
      s2_start = 1'b1;
      @(negedge clock);
      s2_start = 1'b0; s2_in_valid = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         in_data = 16'(cyc * 7);
         #1;
         if (cyc == 3) check("s2 buf_data", s2_buf_data, cyc * 7);
         if (s2_win_valid) begin
            check("s2 win_row", s2_out_row, w2 / 2);
            check("s2 win_col", s2_out_col, w2 % 2);
            check("s2 win_pixel", p2, (2 + 2 * (w2 / 2)) * 5 + 2 + 2 * (w2 % 2) + 1);
            w2++;
         end
         if (s2_frame_done) fd2++;
         if (s2_buf_push) p2++;
         @(negedge clock);
      end
      s2_in_valid = 1'b0;
      #1;
      check("s2 windows", w2, 4);
      check("s2 pushes", p2, 25);
      check("s2 frame_done_cnt", fd2, 1);
      check("s2 idle", {s2_busy, s2_in_ready}, 0);

      // 3x2 image: kernel never fits.
      @(negedge clock);
      sm_start = 1'b1;
      @(negedge clock);
      sm_start = 1'b0; sm_in_valid = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         if (cyc == 1) check("sm buf_data", sm_buf_data, in_data);
         if (sm_win_valid) wm++;
         if (sm_frame_done && fdm_cyc < 0) fdm_cyc = cyc;
         if (sm_buf_push) pm++;
         @(negedge clock);
      end
      sm_in_valid = 1'b0;
      #1;
      check("sm windows", wm, 0);
      check("sm pushes", pm, 6);
      check("sm fd_cycle", fdm_cyc, 7);
      check("sm idle", {sm_busy, sm_in_ready, sm_frame_done}, 0);
      check("sm coord", {sm_out_row, sm_out_col}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
